sha256_msg_schedule: RTL

Message-schedule stage sitting directly upstream of the SHA-256 round core. It accepts one 512-bit padded block as 16 big-endian 32-bit words over a valid/ready stream. It emits Wt, Kt and a round-enable for rounds 0..63, which drive the core's Wt_i, Kt_i and en_i. W0..W15 are passed through as they arrive; W16..W63 are expanded in place from a 16-word sliding window.

---
 rtl/sha256_msg_schedule.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
//   Message-schedule stage feeding the SHA-256 round core. A 512-bit padded
//   block arrives as 16 big-endian 32-bit words on a valid/ready stream.
//   W0..W15 are passed straight through as they are accepted. W16..W63 are
//   expanded in place from a 16-word sliding window. Each issued round
//   presents Wt, Kt and a round enable one cycle after it is produced.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : synchronous active-high reset, overrides everything
//   word_i       : incoming message word (W0 first, most significant word)
//   word_valid_i : word_i is valid
//   word_ready_o : block accepts word_i this cycle (combinational)
//   stall_i      : downstream back-pressure, freezes the schedule
//   Wt_o         : schedule word for the round on round_o
//   Kt_o         : round constant K[round_o]
//   en_o         : round enable; Wt_o/Kt_o/round_o valid when high
//   round_o      : index of the round presented on Wt_o
//   done_o       : one-cycle pulse in the idle cycle after round 63
module sha256_msg_schedule #(
  // Only the FIPS-180-4 values (64 rounds, 16 words) are meaningful.
  parameter int NUM_ROUNDS      = 64,
  parameter int WORDS_PER_BLOCK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  input  logic        stall_i,
  output logic [31:0] Wt_o,
  output logic [31:0] Kt_o,
  output logic        en_o,
  output logic [5:0]  round_o,
  output logic        done_o
);

  localparam logic [5:0] LAST_LOAD  = 6'(WORDS_PER_BLOCK - 1);
  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  // Round constants: first 32 bits of the fractional parts of the cube
  // roots of the first 64 primes.
  localparam logic [31:0] K_TAB [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [31:0] w_reg  [WORDS_PER_BLOCK];
  logic [31:0] w_next [WORDS_PER_BLOCK];

  logic [31:0] wt_reg, wt_next;
  logic [31:0] kt_reg, kt_next;
  logic [5:0]  round_reg, round_next;
  logic        en_reg, en_next;
  logic        done_reg, done_next;

  logic        accept;
  logic        issue_exp;
  logic        issue;
  logic [31:0] expanded;
  logic [31:0] new_word;

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // Handshake and issue qualifiers. rst is folded into ready so that the
  // upstream never sees a ready while the block is being cleared.
  assign word_ready_o = (state_reg == LOAD) & ~stall_i & ~rst;
  assign accept       = (state_reg == LOAD) & word_valid_i & ~stall_i;
  assign issue_exp    = (state_reg == EXPAND) & ~stall_i;
  assign issue        = accept | issue_exp;

  // w[0] is W[t-16], w[1] is W[t-15], w[9] is W[t-7], w[14] is W[t-2].
  // Addition wraps at 32 bits.
  assign expanded = small_sigma1(w_reg[14]) + w_reg[9]
                  + small_sigma0(w_reg[1]) + w_reg[0];

  assign new_word = (state_reg == LOAD) ? word_i : expanded;

  // Sliding window: every issued round (loaded or expanded) shifts one slot.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_win
      if (gi == WORDS_PER_BLOCK - 1) begin : g_tail
        assign w_next[gi] = issue ? new_word : w_reg[gi];
      end else begin : g_body
        assign w_next[gi] = issue ? w_reg[gi+1] : w_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      w_reg[i] <= rst ? 32'd0 : w_next[i];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= LOAD;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LOAD:    if (accept && cnt_reg == LAST_LOAD)     state_next = EXPAND;
      EXPAND:  if (issue_exp && cnt_reg == LAST_ROUND) state_next = DONE;
      DONE:    state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Output / datapath next values. Without an issue, en drops and the
  // presented word, constant and round index hold.
  always_comb begin
    wt_next    = wt_reg;
    kt_next    = kt_reg;
    round_next = round_reg;
    en_next    = 1'b0;
    done_next  = 1'b0;
    cnt_next   = cnt_reg;
    if (issue) begin
      wt_next    = new_word;
      kt_next    = K_TAB[cnt_reg];
      round_next = cnt_reg;
      en_next    = 1'b1;
      // The counter parks on the last round; DONE clears it, so it never
      // relies on a natural 6-bit wrap.
      cnt_next   = (cnt_reg == LAST_ROUND) ? cnt_reg : cnt_reg + 6'd1;
    end
    if (state_reg == DONE) begin
      done_next = 1'b1;
      cnt_next  = 6'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= 6'd0;
      wt_reg    <= 32'd0;
      kt_reg    <= 32'd0;
      round_reg <= 6'd0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      wt_reg    <= wt_next;
      kt_reg    <= kt_next;
      round_reg <= round_next;
      en_reg    <= en_next;
      done_reg  <= done_next;
    end
  end

  assign Wt_o    = wt_reg;
  assign Kt_o    = kt_reg;
  assign round_o = round_reg;
  assign en_o    = en_reg;
  assign done_o  = done_reg;

endmodule
